// File: rtl/sev_seg_mux.sv
// sev_seg_mux: time-multiplexed seven-segment driver for NUM_DIGITS hex digits.
// Hold registers capture x/dp_in/digit_en on a load strobe. A slot counter
// steps through one digit per REFRESH_DIV cycles. Each slot starts with
// BLANK_CYCLES of all-dark output to suppress ghosting.
// Optional feature macro: SEVSEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
// All outputs are registered and active-low.
module sev_seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [4*NUM_DIGITS-1:0] x,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              a_to_g,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] hold_x;
  logic [NUM_DIGITS-1:0]   hold_dp;
  logic [NUM_DIGITS-1:0]   hold_en;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [CW-1:0]           c;
  logic [DW-1:0]           d;

  logic [3:0]              sel_nib;
  logic                    sel_en;
  logic                    sel_dp;
  logic                    sel_zb;
  logic [NUM_DIGITS-1:0]   sel_an;
  logic                    dark;

  // Active-low segment pattern (a..g on bits 6..0) for a hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Hold registers: the display only ever reads these, never the live inputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_x  <= '0;
      hold_dp <= '0;
      hold_en <= '0;
    end else if (load) begin
      hold_x  <= x;
      hold_dp <= dp_in;
      hold_en <= digit_en;
    end
  end

  // Slot counter c and digit index d; d advances when c wraps.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      c <= '0;
      d <= '0;
    end else if (c == C_LAST) begin
      c <= '0;
      d <= (d == D_LAST) ? '0 : d + 1'b1;
    end else begin
      c <= c + 1'b1;
    end
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // Digit i>0 is blanked when it and every higher nibble are zero.
  always_comb begin
    logic upper_zero;
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero & (hold_x[4*i +: 4] == 4'h0);
      lead_zero[i] = upper_zero;
    end
  end
`else
  assign lead_zero = '0;
`endif

  // Select the held data for the current digit and build its anode pattern.
  always_comb begin
    sel_nib = 4'h0;
    sel_en  = 1'b0;
    sel_dp  = 1'b0;
    sel_zb  = 1'b0;
    sel_an  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d == DW'(i)) begin
        sel_nib   = hold_x[4*i +: 4];
        sel_en    = hold_en[i];
        sel_dp    = hold_dp[i];
        sel_zb    = lead_zero[i];
        sel_an[i] = 1'b0;
      end
    end
  end

  assign dark = (c < C_BLANK) | ~sel_en | sel_zb;

  // Registered outputs, loaded from the pre-edge counter and hold state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an     <= '1;
      a_to_g <= 7'b1111111;
      dp     <= 1'b1;
    end else if (dark) begin
      an     <= '1;
      a_to_g <= 7'b1111111;
      dp     <= 1'b1;
    end else begin
      an     <= sel_an;
      a_to_g <= seg_decode(sel_nib);
      dp     <= ~sel_dp;
    end
  end

endmodule

// File: tb/tb_sev_seg_mux.sv
// tb_sev_seg_mux: directed plus randomized stimulus for sev_seg_mux.
// The reference model tracks the number of edges since reset and the held
// values, and derives the expected outputs arithmetically from those.
module tb_sev_seg_mux;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic [15:0]  x = '0;
  logic [3:0]   dp_in = '0;
  logic [3:0]   digit_en = '0;
  logic         load = 1'b0;
  logic [6:0]   a_to_g;
  logic [3:0]   an;
  logic         dp;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release, and held values.
  int          t;
  logic [15:0] mx;
  logic [3:0]  mdp;
  logic [3:0]  men;
  logic [6:0]  seg_tbl [16];

  // Clock generation
  always #5 clk = ~clk;

  sev_seg_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .x       (x),
    .dp_in   (dp_in),
    .digit_en(digit_en),
    .load    (load),
    .a_to_g  (a_to_g),
    .an      (an),
    .dp      (dp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(a_to_g), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
  endtask

  task automatic model_reset();
    t   = 0;
    mx  = '0;
    mdp = '0;
    men = '0;
  endtask

  // One clock edge: predict outputs from the model, advance the model,
  // then compare on the falling edge.
  task automatic tick();
    int          c, d;
    logic        is_dark;
    logic [15:0] sh;
    logic [3:0]  nib;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    c       = t % RD;
    d       = (t / RD) % N;
    sh      = mx >> (4 * d);
    nib     = sh[3:0];
    is_dark = (c < BC) || (men[d] == 1'b0);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && sh == 16'h0) is_dark = 1'b1;
`endif
    if (is_dark) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << d);
      e_seg = seg_tbl[nib];
      e_dp  = ~mdp[d];
    end
    if (load) begin
      mx  = x;
      mdp = dp_in;
      men = digit_en;
    end
    t++;
    @(posedge clk);
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("a_to_g", 32'(a_to_g), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("one_anode", 32'($countones(~an) <= 1), 32'h1);
  endtask

  task automatic do_load(input logic [15:0] nx, input logic [3:0] ndp, input logic [3:0] nen);
    x        = nx;
    dp_in    = ndp;
    digit_en = nen;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic run_random_live(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      x        = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      tick();
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed and randomized sequence
  initial begin
    int guard;
    seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reset held across edges
    repeat (3) @(negedge clk);
    check_dark("reset_hold");
    clr_n = 1'b1;
    model_reset();
    repeat (3) tick();

    // Scan 1234 with dp on digit 2, live x scrambled without load
    do_load(16'h1234, 4'b0100, 4'b1111);
    run_random_live(40);

    // Mid-slot load at c=4 of digit 0
    guard = 0;
    while ((t % (RD * N)) != 4 && guard < 64) begin
      x = 16'($urandom);
      tick();
      guard++;
    end
    check("align_c4_d0", 32'(guard < 64), 32'h1);
    do_load(16'h00AF, 4'b0000, 4'b1111);
    x = 16'($urandom);
    tick();
    check("mid_load_F", 32'(a_to_g), 32'(7'b0111000));
    run_random_live(40);

    // Enable mask and leading-zero handling
    do_load(16'h0007, 4'($urandom), 4'b1011);
    run_random_live(40);

    // Hex decode of every nibble on digit 0
    for (int v = 0; v < 16; v++) begin
      logic [11:0] upper;
      upper = 12'($urandom);
      do_load({upper, 4'(v)}, 4'($urandom), 4'b1111);
      guard = 0;
      while ((t % (RD * N)) != 7 && guard < 40) begin
        tick();
        guard++;
      end
      tick();
      check("hex_decode", 32'(a_to_g), 32'(seg_tbl[v]));
    end

    // Random loads and inputs
    for (int i = 0; i < 300; i++) begin
      x        = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      load     = ($urandom_range(0, 9) == 0);
      tick();
    end
    load = 1'b0;

    // Asynchronous reset mid-slot and mid-load
    x        = 16'hFFFF;
    dp_in    = 4'hF;
    digit_en = 4'hF;
    load     = 1'b1;
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1 check_dark("async_reset");
    @(negedge clk);
    check_dark("reset_held");
    clr_n = 1'b1;
    load  = 1'b0;
    model_reset();
    run_random_live(20);

    // Scan resumes after reset
    do_load(16'($urandom), 4'($urandom), 4'b1111);
    for (int i = 0; i < 100; i++) begin
      x        = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      tick();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
